load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 256, byte size of the attached word memory; legal addresses are 0..MEM_BYTES-1.
REQ-002 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port req_valid, input, 1, CPU request present.
REQ-005 SHALL have port req_ready, output, 1, unit can accept a request.
REQ-006 SHALL have port req_write, input, 1, 1 = store, 0 = load.
REQ-007 SHALL have port req_funct3, input, 3, RISC-V width code: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
REQ-008 SHALL have port req_addr, input, 32, byte address.
REQ-009 SHALL have port req_wdata, input, 32, store data, right-aligned.
REQ-010 SHALL have port resp_valid, output, 1, one-cycle completion pulse.
REQ-011 SHALL have port resp_rdata, output, 32, extended load data (0 for stores and errors).
REQ-012 SHALL have port resp_error, output, 1, misaligned, out-of-range or illegal funct3.
REQ-013 SHALL have ports mem_address (output, 32), mem_write_data (output, 32), mem_read (output, 1), mem_write (output, 1), mem_read_data (input, 32), connected to the word data memory.

Function
REQ-014 SHALL implement FSM states IDLE, READ, WRITE, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL accept a request on the edge where req_valid && req_ready, registering req_write, req_funct3, req_addr and req_wdata.
REQ-016 SHALL flag an error when: the access is misaligned (H with addr[0]=1, W with addr[1:0]!=0); addr >= MEM_BYTES; or funct3 is illegal (loads 011/110/111, stores >= 011).
REQ-017 SHALL, on accept, go IDLE->RESP on error; for a load or SB/SH go IDLE->READ; for SW go IDLE->WRITE.
REQ-018 SHALL, in READ, drive mem_read=1 and mem_address={addr[31:2],2'b00}, and capture mem_read_data at the end of the cycle.
REQ-019 SHALL go READ->RESP for loads and READ->WRITE for SB/SH.
REQ-020 SHALL, in WRITE, drive mem_write=1 for exactly one cycle with stable mem_address and mem_write_data, then go to RESP.
REQ-021 SHALL form mem_write_data for SW as req_wdata; for SB/SH, replace only the addressed byte/halfword of the captured word with wdata[7:0]/wdata[15:0] and leave the other bytes unchanged.
REQ-022 SHALL, for loads, select the byte/halfword using addr[1:0]; sign-extend for LB/LH and zero-extend for LBU/LHU.
REQ-023 SHALL, in RESP, assert resp_valid for one cycle with resp_rdata/resp_error, then return to IDLE; there is no backpressure on the response.
REQ-024 SHALL keep mem_read=0 and mem_write=0 in IDLE and RESP, and never assert both together; an error request performs no memory access.
REQ-025 Latency from the accept edge to resp_valid: load 2 cycles; SW 2; SB/SH 3; error 1.
REQ-026 SHALL ignore req_valid outside IDLE, so a request arriving during a transaction is not accepted.

Reset
REQ-027 SHALL, while reset=0, force state to IDLE and clear all request registers and captured data immediately; outputs are then req_ready=1, resp_valid=0, resp_rdata=0, resp_error=0, mem_read=0, mem_write=0, mem_address=0, mem_write_data=0.
REQ-028 SHALL abandon a transaction reset mid-operation with no response; a WRITE cut short by reset leaves memory contents undefined for that word only.

Structure
REQ-029 SHALL place the funct3 width constants and the FSM state encoding in shared package lsu_pkg.
REQ-030 SHALL put load extraction and store merge in one combinational sub-module, lsu_align; the FSM and registers stay in load_store_unit.

Verification
REQ-031 SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> mem_write pulse 1 cycle; LW resp_rdata=0xDEADBEEF two cycles after accept, resp_error=0.
REQ-032 Word 0x10=0x11223344, SB addr 0x12 data 0xAA -> READ, WRITE, RESP; memory word becomes 0x11AA3344; LB 0x12 -> 0xFFFFFFAA; LBU 0x12 -> 0x000000AA.
REQ-033 Word 0x20=0x8001_7FFF: LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LH 0x20 -> 0x00007FFF.
REQ-034 LW 0x13, SH 0x01, LW 0x100, load funct3=011 -> each gives resp_error=1 one cycle after accept, resp_rdata=0, no mem_read/mem_write.
REQ-035 Assert reset=0 during the READ of an SB -> mem_read drops asynchronously, no resp_valid, req_ready=1 after release, memory word unchanged.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V width codes, FSM state
// encoding and the request legality check.
package lsu_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_WRITE = 2'd2,
      S_RESP  = 2'd3
   } lsu_state_t;

   // Stores only know B/H/W; the unsigned codes are load-only.
   function automatic logic lsu_req_error(input logic        wr,
                                          input logic [2:0]  f3,
                                          input logic [31:0] addr,
                                          input logic [31:0] mem_bytes);
      logic legal;
      logic misaligned;
      if (wr) legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      else    legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                      (f3 == F3_BU) || (f3 == F3_HU);
      misaligned = ((f3[1:0] == 2'b01) && addr[0]) ||
                   ((f3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
      return !legal || misaligned || (addr >= mem_bytes);
   endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data alignment: load lane extraction with sign/zero extension
// and read-modify-write merge of byte/halfword stores into a memory word.
module lsu_align
   import lsu_pkg::*;
(
   input  logic [2:0]  funct3_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] load_word_i,
   input  logic [31:0] store_word_i,
   input  logic [31:0] wdata_i,
   output logic [31:0] load_data_o,
   output logic [31:0] store_data_o
);

   logic [31:0] shifted;

   always_comb begin
      shifted     = load_word_i >> {offset_i, 3'b000};
      load_data_o = 32'd0;
      case (funct3_i)
         F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
         F3_BU:   load_data_o = {24'd0, shifted[7:0]};
         F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
         F3_HU:   load_data_o = {16'd0, shifted[15:0]};
         F3_W:    load_data_o = load_word_i;
         default: load_data_o = 32'd0;
      endcase
   end

   always_comb begin
      store_data_o = store_word_i;
      case (funct3_i)
         F3_B:    store_data_o[{offset_i, 3'b000} +: 8]       = wdata_i[7:0];
         F3_H:    store_data_o[{offset_i[1], 4'b0000} +: 16]  = wdata_i[15:0];
         F3_W:    store_data_o = wdata_i;
         default: store_data_o = store_word_i;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a CPU request port and a word
// memory with combinational read data; sub-word stores use read-modify-write.
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int MEM_BYTES = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic [31:0] mem_address,
   output logic [31:0] mem_write_data,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] mem_read_data,
   output logic [1:0]  dbg_state
);

   lsu_state_t  state_q;
   logic        write_q;
   logic [2:0]  funct3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [31:0] resp_rdata_q;
   logic        resp_error_q;

   logic        req_err_d;
   logic [31:0] load_data;
   logic [31:0] store_data;

   assign req_err_d = lsu_req_error(req_write, req_funct3, req_addr, 32'(MEM_BYTES));

   lsu_align u_align (
      .funct3_i     (funct3_q),
      .offset_i     (addr_q[1:0]),
      .load_word_i  (mem_read_data),
      .store_word_i (rdata_q),
      .wdata_i      (wdata_q),
      .load_data_o  (load_data),
      .store_data_o (store_data)
   );

   // req_valid/req_ready: a request transfers on the rising edge where both are
   // high; req_ready is high only in IDLE. The response is a one-cycle
   // resp_valid pulse with no ready, so the consumer must take it when it comes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= S_IDLE;
         write_q      <= 1'b0;
         funct3_q     <= 3'd0;
         addr_q       <= 32'd0;
         wdata_q      <= 32'd0;
         rdata_q      <= 32'd0;
         resp_rdata_q <= 32'd0;
         resp_error_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (req_valid) begin
                  write_q      <= req_write;
                  funct3_q     <= req_funct3;
                  addr_q       <= req_addr;
                  wdata_q      <= req_wdata;
                  resp_rdata_q <= 32'd0;
                  resp_error_q <= req_err_d;
                  if (req_err_d)                               state_q <= S_RESP;
                  else if (req_write && (req_funct3 == F3_W))  state_q <= S_WRITE;
                  else                                         state_q <= S_READ;
               end
            end
            S_READ: begin
               rdata_q <= mem_read_data;
               if (write_q) begin
                  state_q <= S_WRITE;
               end else begin
                  resp_rdata_q <= load_data;
                  state_q      <= S_RESP;
               end
            end
            S_WRITE: state_q <= S_RESP;
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign req_ready      = (state_q == S_IDLE);
   assign resp_valid     = (state_q == S_RESP);
   assign resp_rdata     = resp_rdata_q;
   assign resp_error     = resp_error_q;
   assign mem_read       = (state_q == S_READ);
   assign mem_write      = (state_q == S_WRITE);
   assign mem_address    = {addr_q[31:2], 2'b00};
   assign mem_write_data = store_data;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit against a 64-word behavioural memory.
module tb_load_store_unit;

   logic        clk;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;
   logic [31:0] mem_address;
   logic [31:0] mem_write_data;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_read_data;
   logic [1:0]  dbg_state;

   int n_checks = 0;
   int n_fail   = 0;
   int rd_cnt   = 0;
   int wr_cnt   = 0;
   int both_cnt = 0;

   logic [31:0] mem [0:63];
   logic [5:0]  mem_idx;

   load_store_unit #(.MEM_BYTES(256)) dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_funct3     (req_funct3),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .resp_valid     (resp_valid),
      .resp_rdata     (resp_rdata),
      .resp_error     (resp_error),
      .mem_address    (mem_address),
      .mem_write_data (mem_write_data),
      .mem_read       (mem_read),
      .mem_write      (mem_write),
      .mem_read_data  (mem_read_data),
      .dbg_state      (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_idx       = mem_address[7:2];
   assign mem_read_data = mem[mem_idx];

   always @(posedge clk) begin
      if (mem_write) mem[mem_idx] <= mem_write_data;
      if (mem_read) rd_cnt++;
      if (mem_write) wr_cnt++;
      if (mem_read && mem_write) both_cnt++;
   end

   // driver: issue one request at #1 after an edge, return after the response
   task automatic do_req(input logic wr, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, output logic [31:0] rdata,
                         output logic err, output int lat);
      req_write  = wr;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      req_valid  = 1'b1;
      rd_cnt     = 0;
      wr_cnt     = 0;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      lat = 1;
      while (!resp_valid && lat < 8) begin
         @(posedge clk);
         #1;
         lat++;
      end
      n_checks++;
      if (resp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL resp_timeout: resp_valid=%b after %0d cycles, required 1", resp_valid, lat);
      end
      rdata = resp_rdata;
      err   = resp_error;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'd0; req_wdata = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      n_checks++;
      if ({req_ready, resp_valid, resp_error, mem_read, mem_write} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_ctrl: rdy,rv,err,rd,wr=%b required 10000",
                  {req_ready, resp_valid, resp_error, mem_read, mem_write});
      end
      n_checks++;
      if ({resp_rdata, mem_address, mem_write_data} !== 96'd0) begin
         n_fail++;
         $display("FAIL reset_data: rdata=%h addr=%h wdata=%h required 0",
                  resp_rdata, mem_address, mem_write_data);
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_sw_lw();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, rd, er, lat);
      n_checks++;
      if (lat !== 2 || wr_cnt !== 1 || rd_cnt !== 0 || er !== 1'b0) begin
         n_fail++;
         $display("FAIL sw: lat=%0d wr=%0d rd=%0d err=%b required 2 1 0 0", lat, wr_cnt, rd_cnt, er);
      end
      n_checks++;
      if (mem[4] !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL sw_mem: got %h required deadbeef", mem[4]);
      end
      do_req(1'b0, 3'b010, 32'h10, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0 || lat !== 2 || rd_cnt !== 1 || wr_cnt !== 0) begin
         n_fail++;
         $display("FAIL lw: data=%h err=%b lat=%0d rd=%0d wr=%0d required deadbeef 0 2 1 0",
                  rd, er, lat, rd_cnt, wr_cnt);
      end
   endtask

   task automatic test_sb_merge();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 3'b010, 32'h10, 32'h11223344, rd, er, lat);
      do_req(1'b1, 3'b000, 32'h12, 32'hFFFFFFAA, rd, er, lat);
      n_checks++;
      if (lat !== 3 || rd_cnt !== 1 || wr_cnt !== 1 || er !== 1'b0) begin
         n_fail++;
         $display("FAIL sb: lat=%0d rd=%0d wr=%0d err=%b required 3 1 1 0", lat, rd_cnt, wr_cnt, er);
      end
      n_checks++;
      if (mem[4] !== 32'h11AA3344) begin
         n_fail++;
         $display("FAIL sb_mem: got %h required 11aa3344", mem[4]);
      end
      do_req(1'b0, 3'b000, 32'h12, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'hFFFFFFAA || er !== 1'b0) begin
         n_fail++;
         $display("FAIL lb: got %h err=%b required ffffffaa 0", rd, er);
      end
      do_req(1'b0, 3'b100, 32'h12, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h000000AA || er !== 1'b0) begin
         n_fail++;
         $display("FAIL lbu: got %h err=%b required 000000aa 0", rd, er);
      end
      do_req(1'b1, 3'b001, 32'h12, 32'h0000BEEF, rd, er, lat);
      n_checks++;
      if (mem[4] !== 32'hBEEF3344 || lat !== 3) begin
         n_fail++;
         $display("FAIL sh_mem: got %h lat=%0d required beef3344 3", mem[4], lat);
      end
   endtask

   task automatic test_halfword();
      logic [31:0] rd; logic er; int lat;
      do_req(1'b1, 3'b010, 32'h20, 32'h80017FFF, rd, er, lat);
      do_req(1'b0, 3'b001, 32'h22, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'hFFFF8001 || er !== 1'b0) begin
         n_fail++;
         $display("FAIL lh_hi: got %h err=%b required ffff8001 0", rd, er);
      end
      do_req(1'b0, 3'b101, 32'h22, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h00008001 || er !== 1'b0) begin
         n_fail++;
         $display("FAIL lhu_hi: got %h err=%b required 00008001 0", rd, er);
      end
      do_req(1'b0, 3'b001, 32'h20, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h00007FFF || er !== 1'b0) begin
         n_fail++;
         $display("FAIL lh_lo: got %h err=%b required 00007fff 0", rd, er);
      end
      do_req(1'b0, 3'b000, 32'h21, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h0000007F || er !== 1'b0) begin
         n_fail++;
         $display("FAIL lb_pos: got %h err=%b required 0000007f 0", rd, er);
      end
   endtask

   task automatic test_errors();
      logic        wr_tab [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
      logic [2:0]  f3_tab [4] = '{3'b010, 3'b001, 3'b010, 3'b011};
      logic [31:0] ad_tab [4] = '{32'h13, 32'h01, 32'h100, 32'h0};
      logic [31:0] rd; logic er; int lat;
      for (int i = 0; i < 4; i++) begin
         do_req(wr_tab[i], f3_tab[i], ad_tab[i], 32'hFFFFFFFF, rd, er, lat);
         n_checks++;
         if (er !== 1'b1 || rd !== 32'd0 || lat !== 1 || rd_cnt !== 0 || wr_cnt !== 0) begin
            n_fail++;
            $display("FAIL err_case%0d: err=%b data=%h lat=%0d rd=%0d wr=%0d required 1 0 1 0 0",
                     i, er, rd, lat, rd_cnt, wr_cnt);
         end
      end
      do_req(1'b1, 3'b011, 32'h10, 32'h0, rd, er, lat);
      n_checks++;
      if (er !== 1'b1 || mem[4] !== 32'hBEEF3344) begin
         n_fail++;
         $display("FAIL err_store_f3: err=%b mem=%h required 1 beef3344", er, mem[4]);
      end
   endtask

   task automatic test_back_to_back();
      int resp_seen = 0;
      logic [31:0] rd; logic er; int lat;
      req_write = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20; req_wdata = 32'h0;
      req_valid = 1'b1;
      rd_cnt = 0;
      @(posedge clk); #1;
      n_checks++;
      if (req_ready !== 1'b0 || mem_read !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_read: ready=%b mem_read=%b required 0 1", req_ready, mem_read);
      end
      @(posedge clk); #1;
      if (resp_valid) resp_seen++;
      n_checks++;
      if (req_ready !== 1'b0 || resp_rdata !== 32'h80017FFF) begin
         n_fail++;
         $display("FAIL b2b_resp: ready=%b data=%h required 0 80017fff", req_ready, resp_rdata);
      end
      req_valid = 1'b0;
      @(posedge clk); #1;
      if (resp_valid) resp_seen++;
      n_checks++;
      if (resp_seen !== 1 || rd_cnt !== 1 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_single: resps=%0d reads=%0d ready=%b required 1 1 1", resp_seen, rd_cnt, req_ready);
      end
      do_req(1'b0, 3'b100, 32'h23, 32'h0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h00000080 || lat !== 2) begin
         n_fail++;
         $display("FAIL b2b_next: got %h lat=%0d required 00000080 2", rd, lat);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd; logic er; int lat;
      int resp_seen = 0;
      do_req(1'b1, 3'b010, 32'h14, 32'h55667788, rd, er, lat);
      req_write = 1'b1; req_funct3 = 3'b000; req_addr = 32'h14; req_wdata = 32'h000000CC;
      req_valid = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
      n_checks++;
      if (mem_read !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_read: mem_read=%b required 1", mem_read);
      end
      #2 reset = 1'b0;
      #1;
      n_checks++;
      if (mem_read !== 1'b0 || mem_write !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_async: rd=%b wr=%b ready=%b required 0 0 1", mem_read, mem_write, req_ready);
      end
      @(negedge clk);
      reset = 1'b1;
      repeat (5) begin
         @(posedge clk); #1;
         if (resp_valid) resp_seen++;
      end
      n_checks++;
      if (resp_seen !== 0 || req_ready !== 1'b1 || mem[5] !== 32'h55667788) begin
         n_fail++;
         $display("FAIL mid_after: resps=%0d ready=%b mem=%h required 0 1 55667788",
                  resp_seen, req_ready, mem[5]);
      end
   endtask

   initial begin
      test_reset();
      test_sw_lw();
      test_sb_merge();
      test_halfword();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      n_checks++;
      if (both_cnt !== 0) begin
         n_fail++;
         $display("FAIL rd_wr_overlap: %0d cycles required 0", both_cnt);
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
